// File: rtl/dsm_dac_out.sv
// Burst-fed sample FIFO released at a fixed rate into a
// 2nd-order delta-sigma modulator driving a 1-bit DAC pin.
module dsm_dac_out #(
  parameter int BITS       = 16,
  parameter int FIFO_ABITS = 4,
  parameter int DIV        = 64,
  parameter int DIV_BITS   = 7,
  parameter int INT_BITS   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITS-1:0]       i_sample,
  input  logic                  i_wren,
  input  logic                  i_clr_flags,
  output logic                  o_dac_out,
  output logic [FIFO_ABITS:0]   o_level,
  output logic                  o_running,
  output logic                  o_underrun,
  output logic                  o_overflow
);

  localparam int DEPTH = 2**FIFO_ABITS;
  localparam int SW    = INT_BITS + 2;
  localparam int FSI   = 2**(BITS-1);
  localparam int IMAX  = 2**(INT_BITS-1) - 1;
  localparam logic [FIFO_ABITS:0] HALF =
    (FIFO_ABITS+1)'(DEPTH/2);
  localparam logic [DIV_BITS-1:0] LAST =
    DIV_BITS'(DIV-1);
  localparam logic signed [SW-1:0] MAXV = SW'(IMAX);
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic signed [SW-1:0] FS   = SW'(FSI);

  typedef enum logic {S_PREFILL, S_RUN} state_t;

  state_t r_state, w_next;

  logic [BITS-1:0]            r_mem [DEPTH];
  logic [FIFO_ABITS:0]        r_wptr, r_rptr;
  logic [DIV_BITS-1:0]        r_cnt, w_cnt_n;
  logic signed [BITS-1:0]     r_x;
  logic signed [INT_BITS-1:0] r_i1, r_i2;
  logic                       r_dac, r_running;
  logic                       r_uf, r_of;

  logic w_empty, w_full, w_tick, w_pop;
  logic w_wr, w_uf_evt, w_of_evt, w_running_n;
  logic [FIFO_ABITS:0] w_level;

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  =
    (r_wptr[FIFO_ABITS-1:0] == r_rptr[FIFO_ABITS-1:0]) &&
    (r_wptr[FIFO_ABITS] != r_rptr[FIFO_ABITS]);

  assign w_tick   = (r_state == S_RUN) && (r_cnt == LAST);
  assign w_pop    = w_tick && !w_empty;
  assign w_uf_evt = w_tick && w_empty;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign w_wr     = i_wren && (!w_full || w_pop);
  assign w_of_evt = i_wren && w_full && !w_pop;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_PREFILL;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_PREFILL: if (w_level >= HALF) w_next = S_RUN;
      S_RUN:     if (w_uf_evt)        w_next = S_PREFILL;
      default:   w_next = S_PREFILL;
    endcase
  end

  // FSM: outputs (divider and run flag)
  always_comb begin
    w_running_n = (w_next == S_RUN);
    w_cnt_n     = '0;
    if (r_state == S_RUN && w_next == S_RUN)
      w_cnt_n = w_tick ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_n;
      r_running <= w_running_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[FIFO_ABITS-1:0]] <= i_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_x    <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_x    <= r_mem[r_rptr[FIFO_ABITS-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_uf <= 1'b0;
      r_of <= 1'b0;
    end else begin
      if (w_uf_evt)         r_uf <= 1'b1;
      else if (i_clr_flags) r_uf <= 1'b0;
      if (w_of_evt)         r_of <= 1'b1;
      else if (i_clr_flags) r_of <= 1'b0;
    end
  end

  function automatic logic signed [INT_BITS-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAXV)      sat = MAXV[INT_BITS-1:0];
    else if (v < MINV) sat = MINV[INT_BITS-1:0];
    else               sat = v[INT_BITS-1:0];
  endfunction

  logic signed [SW-1:0]       w_x_ext, w_fb, w_s1, w_s2;
  logic signed [INT_BITS-1:0] w_i1_n, w_i2_n;

  assign w_x_ext = {{(SW-BITS){r_x[BITS-1]}}, r_x};
  assign w_fb    = r_dac ? FS : -FS;
  assign w_s1    = {{2{r_i1[INT_BITS-1]}}, r_i1} + w_x_ext - w_fb;
  assign w_i1_n  = sat(w_s1);
  assign w_s2    = {{2{r_i2[INT_BITS-1]}}, r_i2}
                 + {{2{w_i1_n[INT_BITS-1]}}, w_i1_n} - w_fb;
  assign w_i2_n  = sat(w_s2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_dac <= 1'b0;
    end else begin
      r_i1  <= w_i1_n;
      r_i2  <= w_i2_n;
      r_dac <= ~w_i2_n[INT_BITS-1];
    end
  end

  assign o_dac_out  = r_dac;
  assign o_level    = w_level;
  assign o_running  = r_running;
  assign o_underrun = r_uf;
  assign o_overflow = r_of;

endmodule

// File: tb/tb_dsm_dac_out.sv
// Bench for dsm_dac_out: vector table, corner sequences and
// random traffic against a queue-based behavioural model.
module tb_dsm_dac_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren;
  logic        clr;
  logic [15:0] smp;
  logic        dac;
  logic [4:0]  level;
  logic        running;
  logic        uf;
  logic        of;

  int n_tests = 0;
  int n_fail  = 0;

  dsm_dac_out dut (
    .clk         (clk),
    .rst         (rst),
    .i_sample    (smp),
    .i_wren      (wren),
    .i_clr_flags (clr),
    .o_dac_out   (dac),
    .o_level     (level),
    .o_running   (running),
    .o_underrun  (uf),
    .o_overflow  (of)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // behavioural model
  int mq[$];
  bit m_run;
  int m_cnt;
  int m_x, m_i1, m_i2;
  bit m_dac, m_uf, m_of;

  function automatic int sat20(int v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_run = 0; m_cnt = 0;
    m_x = 0; m_i1 = 0; m_i2 = 0;
    m_dac = 0; m_uf = 0; m_of = 0;
  endtask

  task automatic m_step(bit w, int s, bit c);
    int fb, lvl0;
    bit tick, pop, ufe, ofe;
    lvl0 = mq.size();
    tick = m_run && (m_cnt == 63);
    pop  = tick && (lvl0 > 0);
    ufe  = tick && (lvl0 == 0);
    fb   = m_dac ? 32768 : -32768;
    m_i1 = sat20(m_i1 + m_x - fb);
    m_i2 = sat20(m_i2 + m_i1 - fb);
    m_dac = (m_i2 >= 0);
    if (pop) m_x = mq.pop_front();
    ofe = 0;
    if (w) begin
      if (mq.size() < 16) mq.push_back(s);
      else ofe = 1;
    end
    if (!m_run) begin
      m_run = (lvl0 >= 8);
      m_cnt = 0;
    end else if (ufe) begin
      m_run = 0;
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1) % 64;
    end
    if (ufe) m_uf = 1; else if (c) m_uf = 0;
    if (ofe) m_of = 1; else if (c) m_of = 0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("dac_out", 32'(dac), 32'(m_dac));
    chk("level", 32'(level), mq.size());
    chk("running", 32'(running), 32'(m_run));
    chk("underrun", 32'(uf), 32'(m_uf));
    chk("overflow", 32'(of), 32'(m_of));
  endtask

  task automatic cyc(bit w, logic [15:0] s, bit c);
    wren = w; smp = s; clr = c;
    @(posedge clk);
    m_step(w, int'($signed(s)), c);
    #1;
    cmp_all();
  endtask

  task automatic do_reset(bit w);
    wren = w; smp = 16'h1234; clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    #1;
    cmp_all();
    rst = 1'b0; wren = 1'b0;
  endtask

  typedef struct {
    bit          r;
    bit          w;
    bit          c;
    logic [15:0] s;
    int          lvl;
    bit          run;
    bit          ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit w, bit c, logic [15:0] s,
                              int lvl, bit run, bit ovf);
    vec_t v;
    v.r = r; v.w = w; v.c = c; v.s = s;
    v.lvl = lvl; v.run = run; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  task automatic dc(logic [15:0] val, int lo, int hi);
    int ones;
    ones = 0;
    do_reset(0);
    for (int i = 0; i < 256 + 4096; i++) begin
      cyc(mq.size() < 12, val, 0);
      if (i >= 256) ones += int'(dac);
    end
    n_tests++;
    if (ones < lo || ones > hi) begin
      n_fail++;
      $display("FAIL density_%0d: got %0d ones, expected %0d..%0d",
               $signed(val), ones, lo, hi);
    end
  endtask

  initial begin
    int t4, n;
    rst = 1'b1; wren = 1'b0; clr = 1'b0; smp = '0;
    m_reset();

    // T1 prefill
    add(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 16'd1000, k, 0, 0);
    add(0, 0, 0, 0, 8, 1, 0);
    // T3 overflow
    add(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++)
      add(0, 1, 0, 16'(k * 100), (k > 16) ? 16 : k, k >= 9, k == 17);
    add(0, 0, 1, 0, 16, 1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].r) do_reset(0);
      else cyc(tbl[i].w, tbl[i].s, tbl[i].c);
      chk("tbl_level", 32'(level), tbl[i].lvl);
      chk("tbl_running", 32'(running), 32'(tbl[i].run));
      chk("tbl_overflow", 32'(of), 32'(tbl[i].ovf));
    end

    // T2 DC density
    dc(16'd16384, 3031, 3113);
    dc(16'd0, 2007, 2089);

    // T4 underrun
    do_reset(0);
    for (int k = 1; k <= 8; k++) cyc(1, 16'(k * 1111 - 4000), 0);
    t4 = 0; n = 0;
    while (t4 == 0 && n < 700) begin
      n++;
      cyc(0, 0, 0);
      if (uf === 1'b1) t4 = n;
    end
    chk("t4_underrun_cycle", t4, 577);
    chk("t4_running", 32'(running), 0);
    chk("t4_level", 32'(level), 0);

    // T5 write+pop while full
    do_reset(0);
    for (int k = 1; k <= 16; k++) cyc(1, 16'(k * 7 + 3), 0);
    chk("t5_full", 32'(level), 16);
    n = 0;
    while (!(m_run && m_cnt == 63) && n < 100) begin
      n++;
      cyc(0, 0, 0);
    end
    cyc(1, 16'h7abc, 0);
    chk("t5_level", 32'(level), 16);
    chk("t5_overflow", 32'(of), 0);

    // T6 reset mid-RUN
    do_reset(0);
    for (int k = 1; k <= 8; k++) cyc(1, 16'(k * 3000), 0);
    n = 0;
    while (!(mq.size() == 5 && m_i1 != 0) && n < 400) begin
      n++;
      cyc(0, 0, 0);
    end
    chk("t6_pre_level", 32'(level), 5);
    do_reset(1);
    chk("t6_level", 32'(level), 0);
    chk("t6_dac", 32'(dac), 0);
    chk("t6_flags", 32'({uf, of}), 0);
    chk("t6_running", 32'(running), 0);
    for (int k = 1; k <= 7; k++) cyc(1, 16'd1000, 0);
    chk("t6_level7", 32'(level), 7);
    chk("t6_run7", 32'(running), 0);
    cyc(1, 16'd1000, 0);
    chk("t6_run8", 32'(running), 0);
    cyc(0, 0, 0);
    chk("t6_run9", 32'(running), 1);

    // randomized traffic
    do_reset(0);
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 999) == 0) begin
          do_reset(1'($urandom_range(0, 1)));
        end else begin
          cyc($urandom_range(0, 99) < ((ph % 2 == 1) ? 90 : 2),
              16'($urandom),
              $urandom_range(0, 49) == 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
